// File: rtl/bf_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf_io_pkg
// Description : Shared definitions for the bf_io_responder block.
//               - DIRECTION_READ / DIRECTION_WRITE encodings of io_dir
//               - state encoding of the CPU-side handshake FSM
// Revision    : 1.0 - initial release
// ============================================================================
package bf_io_pkg;

  // io_dir encodings
  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  // CPU handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,   // waiting for io_req
    ST_SERVE = 2'd1,   // request latched, waiting for FIFO space/data
    ST_ACK   = 2'd2    // io_ack high, waiting for io_req to drop
  } bf_io_state_e;

endpackage : bf_io_pkg
`default_nettype wire

// File: rtl/bf_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bf_byte_fifo
// Description : Synchronous byte FIFO, DEPTH entries (power of two, >= 2).
//               Push to a full FIFO is rejected even if a pop happens in the
//               same cycle; pop of an empty FIFO is ignored. A simultaneous
//               accepted push and pop leaves the level unchanged.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               push, push_data - write request and byte
//               pop             - read request (head advances)
//               full, empty     - occupancy flags
//               level           - occupancy 0..DEPTH
//               head            - byte at the read pointer
// Revision    : 1.0 - initial release
// ============================================================================
module bf_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [7:0]       head
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] c_full_lvl = LVL_W'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Acceptance is judged on the occupancy before this edge, so a full FIFO
  // never takes a push even when it is also being popped.
  assign full      = (r_level == c_full_lvl);
  assign empty     = (r_level == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign level     = r_level;
  assign head      = r_mem[r_rd_ptr];

  // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

endmodule : bf_byte_fifo
`default_nettype wire

// File: rtl/bf_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : bf_io_responder
// Description : CPU I/O responder. A four-phase io_req/io_ack handshake
//               either pushes one byte into the TX FIFO (write) or pops one
//               byte from the RX FIFO (read). The FIFOs are drained/filled by
//               valid/ready byte streams.
// Ports       : clk, rst_n                  - clock, sync active-low reset
//               io_req, io_dir, io_wdata    - CPU request side
//               io_ack, io_rdata            - CPU response side
//               tx_valid/tx_ready/tx_data   - outbound byte stream
//               rx_valid/rx_ready/rx_data   - inbound byte stream
//               tx_level, rx_level          - FIFO occupancies
//               rx_eof                      - input exhausted (BF_IO_EOF_EN)
// Options     : BF_IO_EOF_EN - adds rx_eof; a read of an empty RX FIFO with
//               rx_eof=1 completes with io_rdata=8'h00 instead of stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module bf_io_responder
  import bf_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_req,
  input  logic             io_dir,
  input  logic [7:0]       io_wdata,
  output logic             io_ack,
  output logic [7:0]       io_rdata,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [7:0]       rx_data,
  output logic [LVL_W-1:0] tx_level,
  output logic [LVL_W-1:0] rx_level
`ifdef BF_IO_EOF_EN
  ,
  input  logic             rx_eof
`endif
);

  bf_io_state_e r_state;
  bf_io_state_e w_next_state;

  logic       r_dir;
  logic [7:0] r_wdata;
  logic       r_ack;
  logic [7:0] r_rdata;

  logic       w_tx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] w_rx_head;

  logic       w_tx_push;
  logic       w_rx_pop;
  logic       w_serve_done;
  logic       w_eof_read;
  logic       w_eof;

`ifdef BF_IO_EOF_EN
  assign w_eof = rx_eof;
`else
  assign w_eof = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (io_req)       w_next_state = ST_SERVE;
      ST_SERVE: if (w_serve_done) w_next_state = ST_ACK;
      ST_ACK:   if (!io_req)      w_next_state = ST_IDLE;
      default:                    w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The single FIFO operation of a transaction happens only on
  // the SERVE cycle that completes it, which guarantees one push/pop per
  // handshake no matter how long io_req is held afterwards.
  // --------------------------------------------------------------------------
  always_comb begin
    w_tx_push    = 1'b0;
    w_rx_pop     = 1'b0;
    w_serve_done = 1'b0;
    w_eof_read   = 1'b0;
    if (r_state == ST_SERVE) begin
      if (r_dir == DIRECTION_WRITE) begin
        if (!w_tx_full) begin
          w_tx_push    = 1'b1;
          w_serve_done = 1'b1;
        end
      end else if (!w_rx_empty) begin
        w_rx_pop     = 1'b1;
        w_serve_done = 1'b1;
      end else if (w_eof) begin
        w_eof_read   = 1'b1;
        w_serve_done = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request latch and response registers. Direction and data are captured
  // only at the IDLE sampling edge; later changes on the bus are ignored.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir   <= DIRECTION_READ;
      r_wdata <= 8'h00;
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      if (r_state == ST_IDLE && io_req) begin
        r_dir   <= io_dir;
        r_wdata <= io_wdata;
      end
      if (w_serve_done)                    r_ack <= 1'b1;
      else if (r_state == ST_ACK && !io_req) r_ack <= 1'b0;
      if (w_rx_pop)        r_rdata <= w_rx_head;
      else if (w_eof_read) r_rdata <= 8'h00;
    end
  end

  assign io_ack   = r_ack;
  assign io_rdata = r_rdata;
  assign tx_valid = !w_tx_empty;
  assign tx_data  = w_tx_head;
  assign rx_ready = !w_rx_full;

  // --------------------------------------------------------------------------
  // FIFOs
  // --------------------------------------------------------------------------
  bf_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_tx_push),
    .push_data (r_wdata),
    .pop       (tx_ready),
    .full      (w_tx_full),
    .empty     (w_tx_empty),
    .level     (tx_level),
    .head      (w_tx_head)
  );

  bf_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (w_rx_pop),
    .full      (w_rx_full),
    .empty     (w_rx_empty),
    .level     (rx_level),
    .head      (w_rx_head)
  );

endmodule : bf_io_responder
`default_nettype wire
